// File: rtl/mem_bus_pkg.sv
// Shared types for the memory bus arbiter and its round-robin picker.
package mem_bus_pkg;

  typedef enum logic [1:0] {
    READ    = 2'b00,
    WRITE   = 2'b01,
    READ_B  = 2'b10,
    WRITE_B = 2'b11
  } bus_cmd_t;

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    WAIT,
    DRAIN
  } arb_state_t;

  // Width of a requester index; never narrower than one bit.
  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  // Only reads bring data back to the requester.
  function automatic logic cmd_is_read(input logic [1:0] cmd);
    return (bus_cmd_t'(cmd) == READ) || (bus_cmd_t'(cmd) == READ_B);
  endfunction

endpackage

// File: rtl/mem_bus_arbiter_rr_pick.sv
// Combinational round-robin picker: first pending index after last_grant,
// wrapping around. Kept standalone so other schedulers can reuse it.
module rr_pick import mem_bus_pkg::*; #(
  parameter int NREQ = 2,
  localparam int GW = idx_w(NREQ)
) (
  input  logic [NREQ-1:0] pending,
  input  logic [GW-1:0]   last_grant,
  output logic [GW-1:0]   grant,
  output logic            any_pending
);

  logic [GW-1:0] cand;

  // Scan from last_grant+1 around to last_grant itself; first hit wins.
  always_comb begin
    grant       = '0;
    any_pending = 1'b0;
    cand        = '0;
    for (int k = 1; k <= NREQ; k++) begin
      cand = GW'((int'(last_grant) + k) % NREQ);
      if (!any_pending && pending[cand]) begin
        any_pending = 1'b1;
        grant       = cand;
      end
    end
  end

endmodule

// File: rtl/mem_bus_arbiter.sv
// Shares one toggle-handshake memory port between NREQ requesters with
// round-robin arbitration, one transaction in flight, and a per-request
// timeout that completes a hung request with an error flag.
module mem_bus_arbiter import mem_bus_pkg::*; #(
  parameter int NREQ    = 2,
  parameter int ADDR_W  = 16,
  parameter int DATA_W  = 16,
  parameter int TIMEOUT = 1024,
  localparam int GW = idx_w(NREQ)
) (
  input  logic                   sysclk,
  input  logic                   reset,
  input  logic [NREQ-1:0]        req_run,
  input  logic [NREQ*2-1:0]      req_cmd,
  input  logic [NREQ*ADDR_W-1:0] req_addr,
  input  logic [NREQ*DATA_W-1:0] req_wr_data,
  output logic [NREQ*DATA_W-1:0] req_rd_data,
  output logic [NREQ-1:0]        req_done,
  output logic [NREQ-1:0]        req_err,
  output logic [ADDR_W-1:0]      mem_addr,
  output logic [1:0]             mem_cmd,
  output logic                   mem_run,
  output logic [DATA_W-1:0]      mem_wr_data,
  input  logic [DATA_W-1:0]      mem_rd_data,
  input  logic                   mem_done,
  output logic [GW-1:0]          grant_id,
  output logic                   busy
);

  localparam int TW = $clog2(TIMEOUT) + 1;

  arb_state_t        state, state_nxt;
  logic [NREQ-1:0]   pending;
  logic [GW-1:0]     pick_grant;
  logic              pick_any;
  logic [GW-1:0]     sel;
  logic [GW-1:0]     last_grant;
  logic [TW-1:0]     timer;
  logic              mem_idle;
  logic              do_issue;
  logic              ok_done;
  logic              to_done;
  logic              sel_pending;
  logic [1:0]        sel_cmd;
  logic [ADDR_W-1:0] sel_addr;
  logic [DATA_W-1:0] sel_wdata;

  assign pending  = req_run ^ req_done;
  assign mem_idle = (mem_done == mem_run);

  rr_pick #(.NREQ(NREQ)) u_pick (
    .pending     (pending),
    .last_grant  (last_grant),
    .grant       (pick_grant),
    .any_pending (pick_any)
  );

  // Route the selected requester's command fields to the issue latch.
  always_comb begin
    sel_cmd     = '0;
    sel_addr    = '0;
    sel_wdata   = '0;
    sel_pending = 1'b0;
    for (int i = 0; i < NREQ; i++) begin
      if (sel == GW'(i)) begin
        sel_cmd     = req_cmd[2*i +: 2];
        sel_addr    = req_addr[i*ADDR_W +: ADDR_W];
        sel_wdata   = req_wr_data[i*DATA_W +: DATA_W];
        sel_pending = pending[i];
      end
    end
  end

  // State register.
  always_ff @(posedge sysclk) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  // Next-state logic; a request withdrawn before ISSUE falls back to IDLE.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (pick_any) state_nxt = ISSUE;
      ISSUE:   state_nxt = do_issue ? WAIT : IDLE;
      WAIT:    if (ok_done) state_nxt = IDLE;
               else if (to_done) state_nxt = DRAIN;
      DRAIN:   if (mem_idle) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Per-state event strobes; a memory answer beats the timeout on the same cycle.
  always_comb begin
    do_issue = (state == ISSUE) && sel_pending;
    ok_done  = (state == WAIT) && mem_idle;
    to_done  = (state == WAIT) && !mem_idle && (timer == TW'(TIMEOUT - 1));
    busy     = (state != IDLE);
  end

  // Grant capture, issue latch, watchdog timer and requester completion.
  always_ff @(posedge sysclk) begin
    if (reset) begin
      sel         <= '0;
      last_grant  <= GW'(NREQ - 1);
      timer       <= '0;
      mem_cmd     <= '0;
      mem_addr    <= '0;
      mem_wr_data <= '0;
      mem_run     <= 1'b0;
      grant_id    <= '0;
      req_done    <= '0;
      req_err     <= '0;
      req_rd_data <= '0;
    end else begin
      if (state == IDLE && pick_any) sel <= pick_grant;

      if (do_issue) begin
        mem_cmd     <= sel_cmd;
        mem_addr    <= sel_addr;
        mem_wr_data <= sel_wdata;
        mem_run     <= ~mem_run;
        grant_id    <= sel;
        timer       <= '0;
      end else if (state == WAIT && !mem_idle && timer != '1) begin
        timer <= timer + 1'b1;
      end

      if (ok_done || to_done) last_grant <= sel;

      for (int i = 0; i < NREQ; i++) begin
        if ((ok_done || to_done) && sel == GW'(i)) begin
          req_done[i] <= ~req_done[i];
          req_err[i]  <= to_done;
          if (ok_done && cmd_is_read(mem_cmd))
            req_rd_data[i*DATA_W +: DATA_W] <= mem_rd_data;
        end
      end
    end
  end

endmodule
